// File: rtl/itch_feed_arbiter.sv
// Round-robin, message-granular arbiter sharing one ITCH parser between two
// byte-serial feed sources; regenerates start/end/valid framing for the parser.
module itch_feed_arbiter #(
  parameter int MAX_LEN    = 40,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  input  logic [7:0]       s0_data,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [7:0]       s1_data,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic             out_start_msg,
  output logic             out_end_msg,
  output logic [7:0]       out_message,
  output logic             out_valid,
  output logic             out_src,
  output logic             busy,
  output logic             trunc_err,
  output logic [CNT_W-1:0] msg_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] trunc_cnt
);

  // TRUNC is the single cycle after an over-length byte: nothing accepted,
  // the error is flagged, then the rest of the message is drained.
  typedef enum logic [2:0] {IDLE, FWD, TRUNC, DRAIN, GAP} state_t;

  localparam state_t           AFTER_MSG = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [3:0]       GAP_INIT  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [5:0]       LEN_LIMIT = 6'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [5:0]       byte_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic             last_grant_q;
  logic             out_src_q;
  logic             out_valid_q;
  logic             out_start_q;
  logic             out_end_q;
  logic [7:0]       out_message_q;
  logic             trunc_err_q;
  logic [CNT_W-1:0] msg_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] trunc_cnt_q;

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       pick;
  logic       src_ready;

  assign g_valid = out_src_q ? s1_valid : s0_valid;
  assign g_last  = out_src_q ? s1_last  : s0_last;
  assign g_data  = out_src_q ? s1_data  : s0_data;

  // Prefer the source that did not win last time; fall back to whichever is valid.
  assign pick = last_grant_q ? !s0_valid : s1_valid;

  assign src_ready = (state_q == FWD) || (state_q == DRAIN);
  assign s0_ready  = src_ready && !out_src_q;
  assign s1_ready  = src_ready && out_src_q;
  assign busy      = (state_q != IDLE);

  assign out_start_msg = out_start_q;
  assign out_end_msg   = out_end_q;
  assign out_message   = out_message_q;
  assign out_valid     = out_valid_q;
  assign out_src       = out_src_q;
  assign trunc_err     = trunc_err_q;
  assign msg_cnt       = msg_cnt_q;
  assign stall_cnt     = stall_cnt_q;
  assign trunc_cnt     = trunc_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every read in this block sees the pre-edge value regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      last_grant_q  <= 1'b1;
      out_src_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_start_q   <= 1'b0;
      out_end_q     <= 1'b0;
      out_message_q <= '0;
      trunc_err_q   <= 1'b0;
      msg_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      trunc_cnt_q   <= '0;
    end else begin
      out_valid_q   <= 1'b0;
      out_start_q   <= 1'b0;
      out_end_q     <= 1'b0;
      out_message_q <= '0;
      trunc_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            out_src_q  <= pick;
            byte_cnt_q <= '0;
            state_q    <= FWD;
          end
        end
        FWD: begin
          if (g_valid) begin
            out_valid_q   <= 1'b1;
            out_message_q <= g_data;
            out_start_q   <= (byte_cnt_q == '0);
            out_end_q     <= g_last;
            if (g_last) begin
              msg_cnt_q    <= sat_inc(msg_cnt_q);
              last_grant_q <= out_src_q;
              byte_cnt_q   <= '0;
              gap_cnt_q    <= GAP_INIT;
              state_q      <= AFTER_MSG;
            end else begin
              byte_cnt_q <= byte_cnt_q + 6'd1;
              if (byte_cnt_q == LEN_LIMIT) state_q <= TRUNC;
            end
          end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
          end
        end
        TRUNC: begin
          trunc_err_q <= 1'b1;
          trunc_cnt_q <= sat_inc(trunc_cnt_q);
          state_q     <= DRAIN;
        end
        DRAIN: begin
          if (g_valid && g_last) begin
            last_grant_q <= out_src_q;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= GAP_INIT;
            state_q      <= AFTER_MSG;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_q <= IDLE;
          else                 gap_cnt_q <= gap_cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
